exp_taylor_seq: RTL and testbench
=================================

# exp_taylor_seq

Iterative Taylor-series evaluator for e^x in unsigned Q8.8 fixed point. It is the reading side of the reciprocal-coefficient ROM: it drives the ROM address and consumes its 1/n data words (Q8.8, entry k = 1/(k+1)). It accumulates sum = Σ x^n/n! for n = 0..N_TERMS. It sits between the accelerator's request interface and its result register. The ROM is instantiated outside this block.

## Interface
- N_TERMS, 12: series terms after the constant 1.0; legal range 1..12, bounded by the ROM depth.
- DW, 16: datapath width. The only supported value is 16, Q8.8.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x_in  in  16  operand, unsigned Q8.8; latched when start is accepted.
- rom_addr  out  4  ROM address; n-1 during MULR, otherwise 0.
- rom_data  in  16  ROM word, combinational, valid in the same cycle as rom_addr.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse; result and ovf are valid in this cycle.
- result  out  16  Q8.8 sum; held until the next accepted start.
- ovf  out  1  sticky per operation; set on any saturation.

## Operation
- States: IDLE, MULX, MULR, ACC, DONE.
- IDLE with start=1:
  - x ← x_in, term ← 0x0100, sum ← 0x0100, n ← 1.
  - ovf ← 0, result ← 0.
  - Go to MULX.
- MULX: term ← q88(term × x). Go to MULR.
- MULR:
  - rom_addr = n-1.
  - term ← q88(term × rom_data). Go to ACC.
- ACC: sum ← sat(sum + term).
  - If n = N_TERMS, go to DONE.
  - Otherwise n ← n+1 and go to MULX.
- DONE: result ← sum, done=1, go to IDLE. A start in DONE is ignored.
- start in MULX, MULR, ACC or DONE is ignored. x_in changes after acceptance have no effect.
- q88(a×b):
  - 32-bit unsigned product p; output is p[23:8] (truncation, no rounding).
  - If p[31:24] ≠ 0, output 0xFFFF and set ovf.
- sat(a+b):
  - 17-bit add.
  - On carry, output 0xFFFF and set ovf.
- Iteration is fixed-count: there is no early exit when term reaches 0.
- Once saturated, sum stays 0xFFFF. Later additions re-saturate.
- Reset values: busy=0, done=0, result=0x0000, ovf=0, rom_addr=0, state=IDLE. Internal x, term, sum and n are all 0.
- rst in any state, including mid-iteration, aborts the operation:
  - It returns to IDLE with reset values on the next edge.
  - No done pulse is produced for the aborted operation.
  - rst has priority over start in the same cycle.

## Timing
- Start accepted at edge E0.
- busy=1 from E0 until the edge that leaves DONE.
- One iteration takes 3 cycles (MULX, MULR, ACC).
- done is high in the cycle following edge E0 + 3·N_TERMS + 1. For N_TERMS=12, that is 37 cycles after acceptance.
- result updates on the same edge that raises done.
- Earliest next acceptance is the cycle after done; back-to-back throughput is 3·N_TERMS + 2 cycles.
- rom_addr is combinational from state and n. It must be stable within MULR for the ROM's combinational path.
- The critical path is one 16×16 multiply plus the saturation mux. It is time-shared between MULX and MULR through a single multiplier.

## Structure
- Shared package (accel_pkg):
  - Q88_ONE = 16'h0100, Q88_SAT = 16'hFFFF, RECIP_ROM_DEPTH = 12.
  - State encoding typedef for exp_taylor_seq_state.
- Sub-module q88_mul:
  - Inputs: two 16-bit operands.
  - Outputs: 16-bit truncated or saturated product, plus a sat flag.
  - Purely combinational; instantiated once, with its operand mux driven by state.
- All remaining logic is the FSM, the n counter and the accumulator in exp_taylor_seq.

## Test plan
- x_in=0x0000, N_TERMS=12, start pulse -> done after 37 cycles, result=0x0100, ovf=0. rom_addr steps through 0..11 in the MULR cycles.
- x_in=0x0100 (1.0) -> result=0x02B5, ovf=0; terms 0x100, 0x80, 0x2A, 0x0A, 0x01, then 0.
- x_in=0x0080 (0.5) -> result=0x01A5, ovf=0.
- x_in=0x0800 (8.0) -> the third term's product saturates -> result=0xFFFF, ovf=1, done still at cycle 37.
- x_in=0x0100, rst asserted 10 cycles after acceptance -> next cycle busy=0, done=0, result=0, ovf=0, with no done pulse. A subsequent start with x_in=0x0100 gives 0x02B5.
- Protocol checks:
  - start re-pulsed while busy is ignored, with only one done.
  - start held continuously is re-accepted only from IDLE.
  - x_in changed mid-operation does not alter the result.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator constants and the state type for the Taylor-series e^x sequencer.
package accel_pkg;

    localparam logic [15:0] Q88_ONE         = 16'h0100;
    localparam logic [15:0] Q88_SAT         = 16'hFFFF;
    localparam int unsigned RECIP_ROM_DEPTH = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULX,
        ST_MULR,
        ST_ACC,
        ST_DONE
    } exp_taylor_seq_state;

endpackage

// File: rtl/exp_taylor_seq_q88_mul.sv
// Unsigned Q8.8 x Q8.8 multiply: truncates to Q8.8, saturates when the integer part overflows.
module q88_mul
    import accel_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] p_o,
    output logic        sat_o
);

    logic [31:0] prod;

    assign prod  = {16'b0, a_i} * {16'b0, b_i};
    assign sat_o = |prod[31:24];
    assign p_o   = sat_o ? Q88_SAT : prod[23:8];

endmodule

// File: rtl/exp_taylor_seq.sv
// Iterative e^x = sum x^n/n! evaluator in unsigned Q8.8, reading 1/n from an external ROM.
module exp_taylor_seq
    import accel_pkg::*;
#(
    parameter int unsigned N_TERMS = 12,
    parameter int unsigned DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] x_in,
    output logic [3:0]    rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          ovf
);

    exp_taylor_seq_state state_q;
    logic [15:0] x_q, term_q, sum_q, result_q;
    logic [3:0]  n_q;
    logic        busy_q, done_q, ovf_q;

    logic [15:0] mul_b, mul_p;
    logic        mul_sat;
    logic [16:0] sum_d;

    // One multiplier shared by both product steps; operand B selects x or 1/n.
    assign mul_b = (state_q == ST_MULR) ? rom_data : x_q;

    q88_mul u_mul (
        .a_i   (term_q),
        .b_i   (mul_b),
        .p_o   (mul_p),
        .sat_o (mul_sat)
    );

    assign sum_d = {1'b0, sum_q} + {1'b0, term_q};

    always_comb begin
        rom_addr = '0;
        if (state_q == ST_MULR) begin
            rom_addr = n_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            term_q   <= '0;
            sum_q    <= '0;
            n_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        x_q      <= x_in;
                        term_q   <= Q88_ONE;
                        sum_q    <= Q88_ONE;
                        n_q      <= 4'd1;
                        ovf_q    <= 1'b0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_MULX;
                    end
                end
                ST_MULX: begin
                    term_q  <= mul_p;
                    ovf_q   <= ovf_q | mul_sat;
                    state_q <= ST_MULR;
                end
                ST_MULR: begin
                    term_q  <= mul_p;
                    ovf_q   <= ovf_q | mul_sat;
                    state_q <= ST_ACC;
                end
                ST_ACC: begin
                    sum_q <= sum_d[16] ? Q88_SAT : sum_d[15:0];
                    ovf_q <= ovf_q | sum_d[16];
                    if (n_q == 4'(N_TERMS)) begin
                        state_q <= ST_DONE;
                    end else begin
                        n_q     <= n_q + 4'd1;
                        state_q <= ST_MULX;
                    end
                end
                ST_DONE: begin
                    result_q <= sum_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_exp_taylor_seq.sv
// Directed and randomized checks of exp_taylor_seq against a plain-arithmetic series model.
module tb_exp_taylor_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] x_in, rom_data, result;
    logic [3:0]  rom_addr;
    logic        busy, done, ovf;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Reciprocal ROM: entry k holds 1/(k+1) in Q8.8, truncated.
    always_comb begin
        rom_data = 16'h0000;
        if (rom_addr < 4'd12) rom_data = 16'(256 / (int'(rom_addr) + 1));
    end

    exp_taylor_seq #(.N_TERMS(12), .DW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x_in     (x_in),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_exp(input logic [15:0] x, output logic [15:0] res, output logic ov);
        longint unsigned term, sum, p;
        term = 256;
        sum  = 256;
        ov   = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            p = term * longint'(x);
            if (p >= 64'd16777216) begin term = 65535; ov = 1'b1; end
            else term = p / 256;
            p = term * longint'(256 / n);
            if (p >= 64'd16777216) begin term = 65535; ov = 1'b1; end
            else term = p / 256;
            sum = sum + term;
            if (sum > 65535) begin sum = 65535; ov = 1'b1; end
        end
        res = 16'(sum);
    endfunction

    task automatic run_op(input logic [15:0] x, input logic [15:0] exp_res, input logic exp_ovf,
                          input bit disturb, input string tag);
        int          done_cyc, done_cnt;
        bit          busy_bad, addr_bad;
        logic [15:0] res_at_done, exp_addr;
        logic        ovf_at_done;
        @(negedge clk);
        x_in  = x;
        start = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        busy_bad    = (busy !== 1'b1);
        addr_bad    = 1'b0;
        done_cyc    = -1;
        done_cnt    = 0;
        res_at_done = 16'hxxxx;
        ovf_at_done = 1'bx;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = k;
                    res_at_done = result;
                    ovf_at_done = ovf;
                end
            end
            if (k <= 36 && busy !== 1'b1) busy_bad = 1'b1;
            if (k >= 37 && busy !== 1'b0) busy_bad = 1'b1;
            exp_addr = (k % 3 == 1 && k <= 34) ? 16'((k - 1) / 3) : 16'd0;
            if ({12'd0, rom_addr} !== exp_addr) addr_bad = 1'b1;
            if (disturb) begin
                if (k == 5) x_in = 16'($urandom);
                if (k == 10 || k == 36) start = 1'b1;
            end
        end
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'd37);
        chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, " result"}, {16'd0, res_at_done}, {16'd0, exp_res});
        chk({tag, " ovf"}, {31'd0, ovf_at_done}, {31'd0, exp_ovf});
        chk({tag, " result_held"}, {16'd0, result}, {16'd0, exp_res});
        chk({tag, " busy_window"}, {31'd0, busy_bad}, 32'd0);
        chk({tag, " rom_addr_seq"}, {31'd0, addr_bad}, 32'd0);
    endtask

    initial begin
        logic [15:0] xr, er;
        logic        eo;
        int          d1, d2, dcnt;

        rst   = 1'b1;
        start = 1'b0;
        x_in  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", {16'd0, result}, 32'd0);
        chk("reset ovf", {31'd0, ovf}, 32'd0);
        chk("reset rom_addr", {28'd0, rom_addr}, 32'd0);
        rst = 1'b0;

        run_op(16'h0000, 16'h0100, 1'b0, 1'b0, "x0");
        run_op(16'h0100, 16'h02B5, 1'b0, 1'b0, "x1");
        run_op(16'h0080, 16'h01A5, 1'b0, 1'b0, "xhalf");
        run_op(16'h0800, 16'hFFFF, 1'b1, 1'b0, "x8sat");
        run_op(16'h0100, 16'h02B5, 1'b0, 1'b1, "disturb");

        // Abort mid-iteration with reset.
        @(negedge clk);
        x_in  = 16'h0100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort result", {16'd0, result}, 32'd0);
        chk("abort ovf", {31'd0, ovf}, 32'd0);
        rst  = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        chk("abort no_done", 32'(dcnt), 32'd0);
        run_op(16'h0100, 16'h02B5, 1'b0, 1'b0, "after_abort");

        // Start held high: re-accepted only once back in IDLE.
        @(negedge clk);
        x_in  = 16'h0100;
        start = 1'b1;
        @(posedge clk);
        #1;
        d1   = -1;
        d2   = -1;
        dcnt = 0;
        for (int k = 1; k <= 85; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                dcnt++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == 74) start = 1'b0;
        end
        chk("held first_done", 32'(d1), 32'd37);
        chk("held second_done", 32'(d2), 32'd75);
        chk("held done_count", 32'(dcnt), 32'd2);
        chk("held result", {16'd0, result}, 32'h02B5);
        chk("held busy_end", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            xr = (i % 2 == 1) ? 16'($urandom_range(0, 16'h03FF)) : 16'($urandom);
            ref_exp(xr, er, eo);
            run_op(xr, er, eo, (i % 3 == 0), $sformatf("rand%0d_x%04h", i, xr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
